conv_frame_encoder: RTL and testbench



---
 rtl/conv_frame_encoder.sv | 194 +++++++++++++++++++
 tb/tb_conv_frame_encoder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_encoder.sv
// Rate-1/2 K=3 (G0=7, G1=5) convolutional encoder with K-1 zero tail bits per frame.
// Optional CONV_ERR_INJECT_EN adds LFSR-driven single-bit symbol error injection.
//
// state   | meaning
// S_IDLE  | waiting for first info bit of a frame, shift state is zero
// S_DATA  | accepting info bits
// S_TAIL  | emitting M zero tail bits, info input blocked
// S_DRAIN | waiting for the sym_last symbol to be taken downstream
module conv_frame_encoder #(
  parameter int           MAX_FRAME = 32,
  parameter int           K         = 3,
  parameter logic [K-1:0] G0        = 3'b111,
  parameter logic [K-1:0] G1        = 3'b101
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_bit_valid,
  output logic       o_bit_ready,
  input  logic       i_bit_data,
  input  logic       i_bit_last,
  output logic       o_sym_valid,
  input  logic       i_sym_ready,
  output logic [1:0] o_sym,
  output logic       o_sym_last,
  output logic       o_frame_done,
  output logic       o_trunc,
  output logic       o_busy
`ifdef CONV_ERR_INJECT_EN
  ,
  input  logic [7:0] i_err_thresh,
  output logic [7:0] o_err_count
`endif
);

  localparam int M  = K - 1;
  localparam int CW = $clog2(MAX_FRAME + 1);
  localparam int TW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_FRAME - M);
  localparam logic [TW-1:0] TLAST = TW'(M - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_nstate;
  logic [M-1:0]    r_st;
  logic [CW-1:0]   r_cnt;
  logic [TW-1:0]   r_tcnt;
  logic            r_sym_valid;
  logic [1:0]      r_sym;
  logic            r_sym_last;
  logic            r_frame_done;
  logic            r_trunc;

  logic            w_load_ok;
  logic            w_load;
  logic            w_take;
  logic            w_first;
  logic            w_bit_in;
  logic            w_last_in;
  logic            w_trunc_set;
  logic            w_done;
  logic            w_tail_load;
  logic            w_at_limit;
  logic [K-1:0]    w_r;
  logic [1:0]      w_sym_enc;
  logic [1:0]      w_err_mask;

  assign w_load_ok  = !r_sym_valid || i_sym_ready;
  assign w_at_limit = (r_cnt + CW'(1)) == LIMIT;
  assign w_r        = {r_st, w_bit_in};
  assign w_sym_enc  = {^(w_r & G0), ^(w_r & G1)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate    = r_state;
    o_bit_ready = 1'b0;
    w_load      = 1'b0;
    w_take      = 1'b0;
    w_first     = 1'b0;
    w_bit_in    = 1'b0;
    w_last_in   = 1'b0;
    w_trunc_set = 1'b0;
    w_done      = 1'b0;
    w_tail_load = 1'b0;
    case (r_state)
      S_IDLE, S_DATA: begin
        o_bit_ready = w_load_ok;
        if (i_bit_valid && w_load_ok) begin
          w_load   = 1'b1;
          w_take   = 1'b1;
          w_first  = (r_state == S_IDLE);
          w_bit_in = i_bit_data;
          if (i_bit_last) begin
            w_nstate = S_TAIL;
          end else if (w_at_limit) begin
            w_trunc_set = 1'b1;
            w_nstate    = S_TAIL;
          end else begin
            w_nstate = S_DATA;
          end
        end
      end
      S_TAIL: begin
        if (w_load_ok) begin
          w_load      = 1'b1;
          w_tail_load = 1'b1;
          if (r_tcnt == TLAST) begin
            w_last_in = 1'b1;
            w_nstate  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (r_sym_valid && i_sym_ready) begin
          w_done   = 1'b1;
          w_nstate = S_IDLE;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // Symbol register drains and reloads in the same cycle for full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st         <= '0;
      r_cnt        <= '0;
      r_tcnt       <= '0;
      r_sym_valid  <= 1'b0;
      r_sym        <= 2'b00;
      r_sym_last   <= 1'b0;
      r_frame_done <= 1'b0;
      r_trunc      <= 1'b0;
    end else begin
      r_frame_done <= w_done;
      if (w_load) begin
        r_sym_valid <= 1'b1;
        r_sym       <= w_sym_enc ^ w_err_mask;
        r_sym_last  <= w_last_in;
        r_st        <= w_r[M-1:0];
      end else if (i_sym_ready) begin
        r_sym_valid <= 1'b0;
        r_sym_last  <= 1'b0;
      end
      if (w_done) begin
        r_st  <= '0;
        r_cnt <= '0;
      end else if (w_take) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_tail_load) r_tcnt <= w_last_in ? '0 : r_tcnt + TW'(1);
      if (w_first)          r_trunc <= w_trunc_set;
      else if (w_trunc_set) r_trunc <= 1'b1;
    end
  end

`ifdef CONV_ERR_INJECT_EN
  logic [15:0] r_lfsr;
  logic [7:0]  r_err_count;
  logic        w_flip;

  assign w_flip     = r_lfsr[7:0] < i_err_thresh;
  assign w_err_mask = w_flip ? (r_lfsr[8] ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr      <= 16'hACE1;
      r_err_count <= 8'd0;
    end else if (w_load) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      if (w_first)
        r_err_count <= {7'd0, w_flip};
      else if (w_flip && r_err_count != 8'hFF)
        r_err_count <= r_err_count + 8'd1;
    end
  end

  assign o_err_count = r_err_count;
`else
  assign w_err_mask = 2'b00;
`endif

  assign o_sym_valid  = r_sym_valid;
  assign o_sym        = r_sym;
  assign o_sym_last   = r_sym_last;
  assign o_frame_done = r_frame_done;
  assign o_trunc      = r_trunc;
  assign o_busy       = (r_state != S_IDLE) || r_sym_valid;

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Self-checking bench for conv_frame_encoder: directed frames plus random bits/stalls
// compared against a tap-delay convolution model with zero-tail and length truncation.
module tb_conv_frame_encoder;
  localparam int MAX_FRAME = 32;
  localparam int M         = 2;
  localparam int LIMIT     = MAX_FRAME - M;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_bit_valid = 1'b0;
  logic       i_bit_data = 1'b0;
  logic       i_bit_last = 1'b0;
  logic       i_sym_ready = 1'b0;
  logic       o_bit_ready, o_sym_valid, o_sym_last, o_frame_done, o_trunc, o_busy;
  logic [1:0] o_sym;
`ifdef CONV_ERR_INJECT_EN
  logic [7:0] i_err_thresh = 8'd0;
  logic [7:0] o_err_count;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall_err = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_cyc = -1;
  int stall_pct = 0;
  logic       prev_stall = 1'b0;
  logic [1:0] prev_sym = 2'b00;
  logic       prev_last = 1'b0;
  logic [1:0] got_q[$];
  logic       got_last[$];
  int         got_cyc[$];
  bit         info_q[$];
  logic [1:0] exp_q[$];

  conv_frame_encoder #(.MAX_FRAME(MAX_FRAME)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_bit_valid(i_bit_valid), .o_bit_ready(o_bit_ready),
    .i_bit_data(i_bit_data), .i_bit_last(i_bit_last),
    .o_sym_valid(o_sym_valid), .i_sym_ready(i_sym_ready),
    .o_sym(o_sym), .o_sym_last(o_sym_last),
    .o_frame_done(o_frame_done), .o_trunc(o_trunc), .o_busy(o_busy)
`ifdef CONV_ERR_INJECT_EN
    , .i_err_thresh(i_err_thresh), .o_err_count(o_err_count)
`endif
  );

  always #5 clk = ~clk;

  // Samples mid-low-phase: a symbol seen valid&&ready here transfers at the next rising edge.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!o_sym_valid || o_sym !== prev_sym || o_sym_last !== prev_last))
        stall_err++;
      prev_stall = o_sym_valid && !i_sym_ready;
      prev_sym   = o_sym;
      prev_last  = o_sym_last;
      if (o_sym_valid && i_sym_ready) begin
        got_q.push_back(o_sym);
        got_last.push_back(o_sym_last);
        got_cyc.push_back(cyc);
        if (o_sym_last) last_cyc = cyc;
      end
      if (o_frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    i_sym_ready = (int'($urandom_range(99)) >= stall_pct);
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_last.delete();
    got_cyc.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    last_cyc  = -1;
    stall_err = 0;
  endtask

  task automatic send_bits(input bit with_last, output int n_acc);
    bit acc;
    n_acc = 0;
    foreach (info_q[i]) begin
      acc = 1'b0;
      for (int t = 0; t < 300 && !acc; t++) begin
        step();
        i_bit_valid = 1'b1;
        i_bit_data  = info_q[i];
        i_bit_last  = with_last && (i == info_q.size() - 1);
        #1;
        acc = o_bit_ready;
      end
      if (!acc) begin
        check("bit_accept_timeout", acc, 1);
        break;
      end
      n_acc++;
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 600; t++) begin
      step();
      i_bit_valid = 1'b0;
      i_bit_last  = 1'b0;
      #3;
      if (done_cnt > 0) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_done_seen", seen, 1);
  endtask

  // Reference: each symbol is a convolution of the current bit with the two previous ones.
  task automatic build_exp();
    int n;
    bit x[$];
    bit b0, b1, b2;
    n = info_q.size();
    if (n > LIMIT) n = LIMIT;
    for (int i = 0; i < n; i++) x.push_back(info_q[i]);
    repeat (M) x.push_back(1'b0);
    exp_q.delete();
    for (int i = 0; i < x.size(); i++) begin
      b0 = x[i];
      b1 = (i >= 1) ? x[i-1] : 1'b0;
      b2 = (i >= 2) ? x[i-2] : 1'b0;
      exp_q.push_back({b0 ^ b1 ^ b2, b0 ^ b2});
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_sym"}, got_q[i], exp_q[i]);
      check({tag, "_last"}, got_last[i], (i == exp_q.size() - 1));
    end
    check({tag, "_stall_stable"}, stall_err, 0);
  endtask

  task automatic check_1011(input string tag);
    logic [1:0] k [6];
    k = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3};
    check({tag, "_len"}, got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      check({tag, "_sym"}, got_q[i], k[i]);
      check({tag, "_last"}, got_last[i], (i == 5));
    end
  endtask

  task automatic run_frame(input bit with_last, input int pct);
    int n;
    clear_mon();
    stall_pct = pct;
    send_bits(with_last, n);
    wait_done();
    build_exp();
  endtask

  initial begin
    int n_acc;
    int nlast;
    int len;
    int pct;

    rst_n = 1'b0;
    i_sym_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_sym_valid", o_sym_valid, 0);
    check("rst_sym", o_sym, 0);
    check("rst_sym_last", o_sym_last, 0);
    check("rst_frame_done", o_frame_done, 0);
    check("rst_trunc", o_trunc, 0);
    check("rst_busy", o_busy, 0);
    check("rst_bit_ready", o_bit_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed 1,0,1,1 at full rate
    info_q = '{1'b1, 1'b0, 1'b1, 1'b1};
    run_frame(1'b1, 0);
    check_1011("t1");
    if (got_cyc.size() == 6) check("t1_back_to_back", got_cyc[5] - got_cyc[0], 5);
    check("t1_done_lag", done_cyc - last_cyc, 1);
    check("t1_done_count", done_cnt, 1);
    check("t1_trunc", o_trunc, 0);

    // Single bit frame
    info_q = '{1'b0};
    run_frame(1'b1, 0);
    check_stream("t2");

    // Unterminated run of ones hits the length limit
    clear_mon();
    stall_pct = 0;
    info_q.delete();
    repeat (40) info_q.push_back(1'b1);
    n_acc = 0;
    for (int t = 0; t < 200; t++) begin
      step();
      i_bit_valid = 1'b1;
      i_bit_data  = 1'b1;
      i_bit_last  = 1'b0;
      #3;
      if (done_cnt > 0) break;
      if (o_bit_ready) n_acc++;
    end
    i_bit_valid = 1'b0;
    check("t3_accepted", n_acc, LIMIT);
    check("t3_done", done_cnt, 1);
    build_exp();
    check_stream("t3");
    check("t3_trunc", o_trunc, 1);

    // trunc is sticky until the next frame's first accepted bit
    clear_mon();
    info_q = '{1'b1};
    send_bits(1'b1, n_acc);
    step();
    #1;
    check("t3b_trunc_cleared", o_trunc, 0);
    wait_done();
    build_exp();
    check_stream("t3b");

    // bit_last exactly on the length limit: full frame, no trunc
    info_q.delete();
    repeat (LIMIT) info_q.push_back($urandom_range(1) != 0);
    run_frame(1'b1, 0);
    check_stream("t4");
    check("t4_trunc", o_trunc, 0);

    // 20-bit random frame under 50% backpressure
    info_q.delete();
    repeat (20) info_q.push_back($urandom_range(1) != 0);
    run_frame(1'b1, 50);
    check_stream("t5");

    // Random lengths and stall rates
    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(LIMIT, 1);
      case ($urandom_range(2))
        0:       pct = 0;
        1:       pct = 25;
        default: pct = 75;
      endcase
      info_q.delete();
      repeat (len) info_q.push_back($urandom_range(1) != 0);
      run_frame(1'b1, pct);
      check_stream("t6");
    end

    // Reset while the tail is held off by backpressure
    clear_mon();
    stall_pct = 0;
    info_q.delete();
    repeat (8) info_q.push_back($urandom_range(1) != 0);
    send_bits(1'b1, n_acc);
    stall_pct = 100;
    step();
    i_bit_valid = 1'b0;
    i_bit_last  = 1'b0;
    step();
    #1;
    check("t7_busy_mid_tail", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("t7_async_sym_valid", o_sym_valid, 0);
    check("t7_async_sym", o_sym, 0);
    check("t7_async_sym_last", o_sym_last, 0);
    check("t7_async_busy", o_busy, 0);
    check("t7_async_trunc", o_trunc, 0);
    nlast = 0;
    foreach (got_last[i]) if (got_last[i]) nlast++;
    check("t7_no_sym_last", nlast, 0);
    stall_pct = 0;
    step();
    step();
    rst_n = 1'b1;
    info_q = '{1'b1, 1'b0, 1'b1, 1'b1};
    run_frame(1'b1, 0);
    check_1011("t7_after_reset");

`ifdef CONV_ERR_INJECT_EN
    check("t8_err_count_zero_thresh", o_err_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
